prog_loader: RTL

Byte-stream program loader: the write side of the instruction/data memory that the single-cycle core only reads. It accepts a framed byte stream from an upstream serial receiver and assembles little-endian 32-bit words. It writes those words sequentially into a memory write port and holds the core in reset until a complete, checksum-verified image has been loaded. It sits between the board-level UART receiver and the memory write port, and drives the core's reset.

---
 rtl/prog_loader_pkg.sv | 16 +
 rtl/prog_loader.sv | 119 +++++++++++
 2 files changed

// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the byte-stream program loader.
package prog_loader_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    COUNT = 3'd1,
    DATA  = 3'd2,
    CHECK = 3'd3,
    DONE  = 3'd4,
    ERR   = 3'd5
  } state_t;

  localparam logic [7:0] SYNC_DEF       = 8'hA5;
  localparam int         BYTES_PER_WORD = 4;

endpackage

// File: rtl/prog_loader.sv
// Program loader: frames SYNC/N/data/checksum from a byte stream, writes
// little-endian words sequentially and holds the core in reset until a
// verified image is in memory.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int         ADDR_W = 6,
  parameter logic [7:0] SYNC   = SYNC_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wd,
  output logic              cpu_reset,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam int CAP = 1 << ADDR_W;

  state_t     state, state_nxt;
  logic [1:0] byte_idx;
  logic [7:0] word_idx;   // N is 8 bits, so the index never needs more
  logic [7:0] cnt;
  logic [7:0] sum;
  logic [7:0] b0, b1, b2; // low three bytes of the word being assembled
  logic       xfer, is_sync, last_byte, last_word, bad_cnt;

  assign xfer      = rx_valid & rx_ready;
  assign is_sync   = (rx_data == SYNC);
  assign last_byte = (byte_idx == 2'(BYTES_PER_WORD - 1));
  assign last_word = ((word_idx + 8'd1) == cnt);
  assign bad_cnt   = (rx_data == 8'd0) || ({24'd0, rx_data} > CAP);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic; only a transferred byte can move the FSM.
  always_comb begin
    state_nxt = state;
    if (xfer) begin
      unique case (state)
        IDLE:    if (is_sync) state_nxt = COUNT;
        COUNT:   state_nxt = bad_cnt ? ERR : DATA;
        DATA:    if (last_byte && last_word) state_nxt = CHECK;
        CHECK:   state_nxt = (rx_data == sum) ? DONE : ERR;
        DONE:    if (is_sync) state_nxt = COUNT;
        ERR:     if (is_sync) state_nxt = COUNT;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Word assembly, memory write port and registered status flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_ready  <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wd    <= '0;
      cpu_reset <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      byte_idx  <= '0;
      word_idx  <= '0;
      cnt       <= '0;
      sum       <= '0;
      b0        <= '0;
      b1        <= '0;
      b2        <= '0;
    end else begin
      rx_ready  <= 1'b1;
      mem_we    <= 1'b0;
      // Flags track the state being entered so they change with it.
      busy      <= (state_nxt == COUNT) || (state_nxt == DATA) || (state_nxt == CHECK);
      done      <= (state_nxt == DONE);
      error     <= (state_nxt == ERR);
      cpu_reset <= (state_nxt != DONE);
      if (xfer) begin
        unique case (state)
          IDLE, DONE, ERR: begin
            if (is_sync) begin
              byte_idx <= '0;
              word_idx <= '0;
              sum      <= '0;
            end
          end
          COUNT: cnt <= rx_data;
          DATA: begin
            sum      <= sum + rx_data;
            byte_idx <= byte_idx + 2'd1;
            unique case (byte_idx)
              2'd0:    b0 <= rx_data;
              2'd1:    b1 <= rx_data;
              2'd2:    b2 <= rx_data;
              default: begin
                mem_we   <= 1'b1;
                mem_addr <= ADDR_W'(word_idx);
                mem_wd   <= {rx_data, b2, b1, b0};
                word_idx <= word_idx + 8'd1;
              end
            endcase
          end
          default: ;
        endcase
      end
    end
  end

endmodule
